// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM encoding, default APB decode constants and status bit layout
package uart_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;
    localparam logic [1:0]  DEF_SEL_CODE    = 2'b10;
    localparam logic [31:0] DEF_TX_ADDR     = 32'd15;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'd16;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_CNT   = 3;
endpackage

// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: APB slave-side bus bundle for the UART sequencer
interface uart_tx_sequencer_if;
    logic [1:0]  psel;
    logic        pen;
    logic        pwr;
    logic [31:0] pAdd;
    logic [31:0] pwData;
    logic [31:0] prdata;
    logic        pready;
    modport master(output psel, pen, pwr, pAdd, pwData, input prdata, pready);
    modport slave(input psel, pen, pwr, pAdd, pwData, output prdata, pready);
endinterface

// File: rtl/word_fifo.sv
// word_fifo: synchronous FIFO with power-of-2 depth and an occupancy count
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + AW'(1) : wp;
            rp    <= do_pop ? rp + AW'(1) : rp;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: APB word FIFO feeding a UART byte transmitter MSB byte first
module uart_tx_sequencer
    import uart_ctrl_pkg::*;
#(
    parameter logic [1:0]  SEL_CODE    = DEF_SEL_CODE,
    parameter logic [31:0] TX_ADDR     = DEF_TX_ADDR,
    parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_sequencer_if.slave            apb,
    output logic [7:0]                    tx_byte,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    state_t      state;
    logic [31:0] shreg, dout, status;
    logic [1:0]  byte_idx;
    logic        sel, tx_wr, push, pop, full, empty;
    assign sel        = apb.psel == SEL_CODE && apb.pen;
    assign tx_wr      = apb.pwr && apb.pAdd == TX_ADDR;
    assign apb.pready = sel && (!tx_wr || !full);
    assign push       = apb.pready && tx_wr;
    assign pop        = state == LOAD;
    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_BUSY]  = state != IDLE;
        status[ST_CNT+:3] = 3'(fifo_cnt);
    end
    assign apb.prdata = (sel && !apb.pwr && apb.pAdd == STATUS_ADDR) ? status : '0;
    word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(apb.pwData),
        .dout(dout), .full(full), .empty(empty), .count(fifo_cnt)
    );
    // tx_start/tx_byte are set on entry to START so they are valid during that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            tx_byte  <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: state <= empty ? IDLE : LOAD;
                LOAD: begin
                    shreg    <= dout;
                    byte_idx <= '0;
                    tx_byte  <= dout[31:24];
                    tx_start <= 1'b1;
                    state    <= START;
                end
                START: state <= WAIT_BUSY;
                WAIT_BUSY: state <= tx_busy ? WAIT_DONE : WAIT_BUSY;
                WAIT_DONE: begin
                    if (!tx_busy && byte_idx != 2'd3) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx + 2'd1;
                        tx_byte  <= shreg[23:16];
                        tx_start <= 1'b1;
                        state    <= START;
                    end else if (!tx_busy) begin
                        state <= empty ? IDLE : LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
